// File: rtl/mux_scan_sequencer_if.sv
// +--------------------------------------------------------------------------+
// | mux_scan_sequencer_if : control, mux select/return and sample stream.    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface mux_scan_sequencer_if #(
  parameter int NUM_CH = 32,
  parameter int SEL_W  = 5,
  parameter int DATA_W = 8
);
  logic              start;
  logic              continuous;
  logic              stop;
  logic [NUM_CH-1:0] chan_mask;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] mux_out;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [SEL_W-1:0]  out_chan;
  logic              busy;
  logic              done;
  logic [15:0]       sample_cnt;

  modport master (
    output start, continuous, stop, chan_mask, mux_out, out_ready,
    input  sel, out_valid, out_data, out_chan, busy, done, sample_cnt
  );

  modport slave (
    input  start, continuous, stop, chan_mask, mux_out, out_ready,
    output sel, out_valid, out_data, out_chan, busy, done, sample_cnt
  );
endinterface

`default_nettype wire

// File: rtl/mux_scan_sequencer.sv
// +--------------------------------------------------------------------------+
// | mux_scan_sequencer : scans enabled mux channels, emits tagged samples.   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module mux_scan_sequencer #(
  parameter int NUM_CH  = 32,
  parameter int SEL_W   = 5,
  parameter int DATA_W  = 8,
  parameter int MUX_LAT = 0
) (
  input  wire logic         clk,
  input  wire logic         rst,
  mux_scan_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_EMIT   = 2'd2
  } state_t;

  localparam logic [1:0] C_WAIT_INIT = MUX_LAT[1:0];

  state_t              r_state, w_state;
  logic [NUM_CH-1:0]   r_mask, w_mask;
  logic                r_cont, w_cont;
  logic                r_stop_pend, w_stop_pend;
  logic [1:0]          r_wait, w_wait;
  logic [SEL_W-1:0]    r_sel, w_sel;
  logic                r_out_valid, w_out_valid;
  logic [DATA_W-1:0]   r_out_data, w_out_data;
  logic [SEL_W-1:0]    r_out_chan, w_out_chan;
  logic                r_busy, w_busy;
  logic                r_done, w_done;
  logic [15:0]         r_sample_cnt, w_sample_cnt;

  logic                w_low_found, w_up_found;
  logic [SEL_W-1:0]    w_low_idx, w_up_idx;

  // Descending scans so the last hit, i.e. the lowest qualifying index, wins.
  always_comb begin
    w_low_found = 1'b0;
    w_low_idx   = '0;
    w_up_found  = 1'b0;
    w_up_idx    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.chan_mask[i]) begin
        w_low_found = 1'b1;
        w_low_idx   = i[SEL_W-1:0];
      end
      if (r_mask[i] && (i > int'(r_sel))) begin
        w_up_found = 1'b1;
        w_up_idx   = i[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    w_state      = r_state;
    w_mask       = r_mask;
    w_cont       = r_cont;
    w_stop_pend  = r_stop_pend;
    w_wait       = r_wait;
    w_sel        = r_sel;
    w_out_valid  = r_out_valid;
    w_out_data   = r_out_data;
    w_out_chan   = r_out_chan;
    w_done       = 1'b0;
    w_sample_cnt = r_sample_cnt;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          if (w_low_found) begin
            w_mask       = bus.chan_mask;
            w_cont       = bus.continuous;
            w_stop_pend  = 1'b0;
            w_sample_cnt = '0;
            w_sel        = w_low_idx;
            w_wait       = C_WAIT_INIT;
            w_state      = ST_SETTLE;
          end else begin
            w_done = 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (bus.stop) w_stop_pend = 1'b1;
        if (r_wait == 2'd0) begin
          w_out_data  = bus.mux_out;
          w_out_chan  = r_sel;
          w_out_valid = 1'b1;
          w_state     = ST_EMIT;
        end else begin
          w_wait = r_wait - 2'd1;
        end
      end
      ST_EMIT: begin
        if (bus.stop) w_stop_pend = 1'b1;
        if (r_out_valid && bus.out_ready) begin
          w_out_valid  = 1'b0;
          w_sample_cnt = (r_sample_cnt == 16'hFFFF) ? r_sample_cnt : r_sample_cnt + 16'd1;
          if (r_stop_pend || bus.stop) begin
            w_state = ST_IDLE;
            w_done  = 1'b1;
          end else if (w_up_found) begin
            w_sel   = w_up_idx;
            w_wait  = C_WAIT_INIT;
            w_state = ST_SETTLE;
          end else if (r_cont && w_low_found) begin
            w_mask  = bus.chan_mask;
            w_sel   = w_low_idx;
            w_wait  = C_WAIT_INIT;
            w_state = ST_SETTLE;
          end else begin
            w_state = ST_IDLE;
            w_done  = 1'b1;
          end
        end
      end
      default: w_state = ST_IDLE;
    endcase
    w_busy = (w_state != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_mask       <= '0;
      r_cont       <= 1'b0;
      r_stop_pend  <= 1'b0;
      r_wait       <= '0;
      r_sel        <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_chan   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_sample_cnt <= '0;
    end else begin
      r_state      <= w_state;
      r_mask       <= w_mask;
      r_cont       <= w_cont;
      r_stop_pend  <= w_stop_pend;
      r_wait       <= w_wait;
      r_sel        <= w_sel;
      r_out_valid  <= w_out_valid;
      r_out_data   <= w_out_data;
      r_out_chan   <= w_out_chan;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_sample_cnt <= w_sample_cnt;
    end
  end

  assign bus.sel        = r_sel;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_chan   = r_out_chan;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.sample_cnt = r_sample_cnt;

endmodule

`default_nettype wire
